// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU operation sequencer: accepts an opcode, drives ALU selects and load strobes, returns a response.
// Optional ALU_SEQ_ZERO_LATCH_EN: zero_flag captures out_Zero_Detect in the result-capture cycle.
module alu_op_sequencer #(
    parameter int LATENCY = 15
) (
    input  logic       Tclkpos,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] opcode,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_err,
    output logic       ALU_Control0,
    output logic       ALU_Control1,
    output logic       SUB,
    output logic       STL,
    output logic       Adder_Cin,
    output logic       A_mux,
    output logic       B_mux0,
    output logic       B_mux1,
    output logic       mux3_0,
    output logic       mux3_1,
    output logic       A_Fclkpos,
    output logic       ALU_O_Fclkpos,
    input  logic       out_Zero_Detect,
    output logic       zero_flag
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [5:0] WAIT_INIT = 6'(LATENCY - 2);

    logic [2:0] state;
    logic [2:0] op_q;
    logic [5:0] cnt;
    logic [9:0] ctl;
    logic       err_q;

    // Control word order: ctl1:0, SUB, STL, Cin, A_mux, B_mux1:0, mux3_1:0
    function automatic logic [9:0] decode(input logic [2:0] op);
        logic [9:0] w;
        w = 10'b0;
        case (op)
            3'd0:    w = 10'b10_0_0_0_1_11_01;
            3'd1:    w = 10'b10_1_0_1_1_11_01;
            3'd2:    w = 10'b00_0_0_0_1_11_01;
            3'd3:    w = 10'b01_0_0_0_1_11_01;
            3'd4:    w = 10'b11_0_1_1_1_11_01;
            3'd5:    w = 10'b10_0_0_0_0_10_01;
            default: w = 10'b00_0_0_0_0_00_00;
        endcase
        return w;
    endfunction

    always_ff @(posedge Tclkpos) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= 3'd0;
            cnt   <= 6'd0;
            ctl   <= 10'd0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q <= opcode;
                        if (opcode == 3'd7) begin
                            // Illegal opcode: answer immediately, keep the datapath selects untouched
                            state <= S_RESP;
                            err_q <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                            err_q <= 1'b0;
                            ctl   <= decode(opcode);
                        end
                    end
                end
                S_LOAD: begin
                    if (op_q == 3'd6) begin
                        state <= S_CAPTURE;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 6'd0) state <= S_CAPTURE;
                    else             cnt   <= cnt - 6'd1;
                end
                S_CAPTURE: state <= S_RESP;
                S_RESP: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign op_ready      = (state == S_IDLE);
    assign resp_valid    = (state == S_RESP);
    assign resp_err      = err_q;
    assign A_Fclkpos     = (state == S_LOAD);
    assign ALU_O_Fclkpos = (state == S_CAPTURE);

    assign {ALU_Control1, ALU_Control0, SUB, STL, Adder_Cin, A_mux,
            B_mux1, B_mux0, mux3_1, mux3_0} = ctl;

`ifdef ALU_SEQ_ZERO_LATCH_EN
    logic zf_q;
    always_ff @(posedge Tclkpos) begin
        if (reset)                   zf_q <= 1'b0;
        else if (state == S_CAPTURE) zf_q <= out_Zero_Detect;
    end
    assign zero_flag = zf_q;
`else
    logic unused_zero;
    assign unused_zero = out_Zero_Detect;
    assign zero_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against a per-transaction timeline model.
module tb_alu_op_sequencer;

    localparam int LAT = 15;

    logic       Tclkpos = 1'b0;
    logic       reset, op_valid, resp_ready, out_Zero_Detect;
    logic [2:0] opcode;
    logic       op_ready, resp_valid, resp_err;
    logic       ALU_Control0, ALU_Control1, SUB, STL, Adder_Cin, A_mux;
    logic       B_mux0, B_mux1, mux3_0, mux3_1;
    logic       A_Fclkpos, ALU_O_Fclkpos, zero_flag;
    logic [9:0] ctl_word;

    int         n_chk = 0;
    int         n_err = 0;
    logic [9:0] ctl_exp;
    logic       zf_exp;

    always #5 Tclkpos = ~Tclkpos;

    alu_op_sequencer #(.LATENCY(LAT)) dut (
        .Tclkpos(Tclkpos), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
        .ALU_Control0(ALU_Control0), .ALU_Control1(ALU_Control1), .SUB(SUB), .STL(STL),
        .Adder_Cin(Adder_Cin), .A_mux(A_mux), .B_mux0(B_mux0), .B_mux1(B_mux1),
        .mux3_0(mux3_0), .mux3_1(mux3_1), .A_Fclkpos(A_Fclkpos), .ALU_O_Fclkpos(ALU_O_Fclkpos),
        .out_Zero_Detect(out_Zero_Detect), .zero_flag(zero_flag)
    );

    assign ctl_word = {ALU_Control1, ALU_Control0, SUB, STL, Adder_Cin, A_mux,
                       B_mux1, B_mux0, mux3_1, mux3_0};

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Select table written straight from the opcode list
    function automatic logic [9:0] ctl_of(input logic [2:0] op);
        case (op)
            3'd0:    return {2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b01};
            3'd1:    return {2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 2'b01};
            3'd2:    return {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b01};
            3'd3:    return {2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b01};
            3'd4:    return {2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01};
            3'd5:    return {2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01};
            default: return 10'd0;
        endcase
    endfunction

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            reset           = 1'b0;
            op_valid        = 1'b0;
            resp_ready      = 1'($urandom_range(0, 1));
            out_Zero_Detect = 1'($urandom_range(0, 1));
            @(negedge Tclkpos);
            chk("idle_op_ready", op_ready, 1);
            chk("idle_a_strobe", A_Fclkpos, 0);
            chk("idle_o_strobe", ALU_O_Fclkpos, 0);
            chk("idle_resp_valid", resp_valid, 0);
            chk("idle_ctl", ctl_word, ctl_exp);
            chk("idle_zero_flag", zero_flag, zf_exp);
            @(posedge Tclkpos);
        end
    endtask

    // One transaction, cycle k=0 being the accept cycle. abort_k >= 0 asserts reset in that cycle.
    task automatic run_op(input logic [2:0] op, input int rdy_wait, input int abort_k);
        int cap, rs, last;
        cap  = (op == 3'd7) ? -1 : ((op == 3'd6) ? 2 : 1 + LAT);
        rs   = (op == 3'd7) ? 1 : cap + 1;
        last = rs + rdy_wait;
        for (int k = 0; k <= last; k++) begin
            #1;
            op_valid        = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            opcode          = (k == 0) ? op : 3'($urandom_range(0, 7));
            resp_ready      = (k == last) ? 1'b1 : ((k >= rs) ? 1'b0 : 1'($urandom_range(0, 1)));
            out_Zero_Detect = 1'($urandom_range(0, 1));
            reset           = (k == abort_k);
            @(negedge Tclkpos);
            chk("op_ready", op_ready, int'(k == 0));
            chk("a_strobe", A_Fclkpos, int'(op != 3'd7 && k == 1));
            chk("o_strobe", ALU_O_Fclkpos, int'(k == cap));
            chk("resp_valid", resp_valid, int'(k >= rs));
            if (k >= rs) chk("resp_err", resp_err, int'(op == 3'd7));
            chk("ctl", ctl_word, ctl_exp);
            chk("zero_flag", zero_flag, zf_exp);
            @(posedge Tclkpos);
            if (k == abort_k) begin
                ctl_exp = 10'd0;
                zf_exp  = 1'b0;
                check_idle(4);
                return;
            end
            if (k == 0 && op != 3'd7) ctl_exp = ctl_of(op);
`ifdef ALU_SEQ_ZERO_LATCH_EN
            if (k == cap) zf_exp = out_Zero_Detect;
`endif
        end
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; opcode = 3'd0; resp_ready = 1'b0; out_Zero_Detect = 1'b0;
        ctl_exp = 10'd0; zf_exp = 1'b0;
        repeat (2) @(posedge Tclkpos);
        check_idle(2);

        run_op(3'd0, 0, -1);
        run_op(3'd1, 0, -1);
        run_op(3'd7, 0, -1);
        run_op(3'd6, 0, -1);
        run_op(3'd2, 4, -1);
        run_op(3'd1, 0, 6);
        run_op(3'd5, 1, -1);
        run_op(3'd7, 3, -1);
        run_op(3'd4, 0, -1);
        for (int t = 0; t < 40; t++)
            run_op(3'($urandom_range(0, 7)), $urandom_range(0, 5), ($urandom_range(0, 9) == 0) ? 4 : -1);
        run_op(3'd3, 2, -1);
        check_idle(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule
